instr_encoder_loader: RTL and testbench

- Sequential instruction encoder and program loader; the encode-side counterpart of the instruction decoder/controller.
- Accepts decoded instruction fields (class, function, register numbers, immediate, jump target) over a valid/ready stream.
- Packs each into an instruction word whose opcode slice decodes back to the same control signals.
- Writes words to consecutive instruction-memory addresses and holds the CPU in reset-hold while loading.

---
 rtl/instr_encoder_loader_pkg.sv | 39 +++
 rtl/instr_encoder_loader_packer.sv | 64 ++++++
 rtl/instr_encoder_loader.sv | 126 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode/function defines plus the loader's class codes, field layout and state type.
package instr_encoder_loader_pkg;

   localparam logic [1:0] REGISTER_TYPE_OPCODE             = 2'b00;
   localparam logic [1:0] IMMEDIATE_TYPE_OPCODE            = 2'b01;
   localparam logic [2:0] SHIFT_TYPE_OPCODE                = 3'b100;
   localparam logic [2:0] MEMORY_TYPE_OPCODE               = 3'b101;
   localparam logic [2:0] CONDITIONAL_JUMP_TYPE_OPCODE     = 3'b110;
   localparam logic [3:0] NON_CONDITIONAL_JUMP_TYPE_OPCODE = 4'b1110;

   localparam logic [1:0] STM_FN = 2'b00;
   localparam logic [1:0] LDM_FN = 2'b01;
   localparam logic [1:0] BZ_FN  = 2'b00;
   localparam logic [1:0] BC_FN  = 2'b01;
   localparam logic [1:0] BNZ_FN = 2'b10;
   localparam logic [1:0] BNC_FN = 2'b11;

   localparam logic [2:0] CLS_R     = 3'd0;
   localparam logic [2:0] CLS_I     = 3'd1;
   localparam logic [2:0] CLS_SHIFT = 3'd2;
   localparam logic [2:0] CLS_MEM   = 3'd3;
   localparam logic [2:0] CLS_CJMP  = 3'd4;
   localparam logic [2:0] CLS_JMP   = 3'd5;

   localparam int unsigned OPC_LSB = 14;
   localparam int unsigned OPC_W   = 6;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned RS_LSB  = 8;
   localparam int unsigned RT_LSB  = 5;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned IMM_W   = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packer: decoded instruction fields -> instruction word, flags illegal bundles.
module instr_field_packer
   import instr_encoder_loader_pkg::*;
#(
   parameter int unsigned INSTR_W = 20,
   parameter int unsigned ADDR_W  = 12
) (
   input  logic [2:0]         cls_i,
   input  logic [2:0]         fn_i,
   input  logic [2:0]         rd_i,
   input  logic [2:0]         rs_i,
   input  logic [2:0]         rt_i,
   input  logic [7:0]         imm_i,
   input  logic [ADDR_W-1:0]  target_i,
   output logic [INSTR_W-1:0] word_o,
   output logic               illegal_o
);

   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (cls_i)
         CLS_R: begin
            word_o[OPC_LSB +: OPC_W] = {REGISTER_TYPE_OPCODE, 1'b0, fn_i};
            word_o[RD_LSB +: REG_W]  = rd_i;
            word_o[RS_LSB +: REG_W]  = rs_i;
            word_o[RT_LSB +: REG_W]  = rt_i;
         end
         CLS_I: begin
            word_o[OPC_LSB +: OPC_W] = {IMMEDIATE_TYPE_OPCODE, 1'b0, fn_i};
            word_o[RD_LSB +: REG_W]  = rd_i;
            word_o[RS_LSB +: REG_W]  = rs_i;
            word_o[0 +: IMM_W]       = imm_i;
         end
         CLS_SHIFT: begin
            word_o[OPC_LSB +: OPC_W] = {SHIFT_TYPE_OPCODE, fn_i};
            word_o[RD_LSB +: REG_W]  = rd_i;
            word_o[RS_LSB +: REG_W]  = rs_i;
            word_o[0 +: IMM_W]       = imm_i;
         end
         CLS_MEM: begin
            // Only store/load multiple have a decode; anything else leaves the word at zero.
            if (fn_i[1:0] == STM_FN || fn_i[1:0] == LDM_FN) begin
               word_o[OPC_LSB +: OPC_W] = {MEMORY_TYPE_OPCODE, fn_i[1:0], 1'b0};
               word_o[RD_LSB +: REG_W]  = rd_i;
               word_o[RS_LSB +: REG_W]  = rs_i;
               word_o[0 +: IMM_W]       = imm_i;
            end else begin
               illegal_o = 1'b1;
            end
         end
         CLS_CJMP: begin
            word_o[OPC_LSB +: OPC_W] = {CONDITIONAL_JUMP_TYPE_OPCODE, fn_i[1:0], 1'b0};
            word_o[0 +: IMM_W]       = imm_i;
         end
         CLS_JMP: begin
            word_o[OPC_LSB +: OPC_W] = {NON_CONDITIONAL_JUMP_TYPE_OPCODE, 2'b00};
            word_o[ADDR_W-1:0]       = target_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field bundles and writes them to consecutive imem addresses
// while holding the CPU.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int unsigned INSTR_W = 20,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned CNT_W   = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [CNT_W-1:0]   count,
   input  logic               abort,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         cls,
   input  logic [2:0]         fn,
   input  logic [2:0]         rd,
   input  logic [2:0]         rs,
   input  logic [2:0]         rt,
   input  logic [7:0]         imm,
   input  logic [ADDR_W-1:0]  target,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               done,
   output logic               err
);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [CNT_W-1:0]     rem_q, rem_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    waddr_q, waddr_d;
   logic [INSTR_W-1:0]   wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [INSTR_W-1:0]   packed_word;
   logic                 packed_illegal;

   instr_field_packer #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W)
   ) u_packer (
      .cls_i     (cls),
      .fn_i      (fn),
      .rd_i      (rd),
      .rs_i      (rs),
      .rt_i      (rt),
      .imm_i     (imm),
      .target_i  (target),
      .word_o    (packed_word),
      .illegal_o (packed_illegal)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = count;
               err_d   = 1'b0;
               state_d = (count == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            // Abort wins over a bundle presented in the same cycle.
            if (abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               if (packed_illegal) begin
                  err_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  waddr_d = addr_q;
                  wdata_d = packed_word;
                  addr_d  = addr_q + 1'b1;
                  rem_d   = rem_q - 1'b1;
                  if (rem_q == CNT_W'(1)) begin
                     state_d = DONE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign in_ready   = (state_q == LOAD);
   assign cpu_hold   = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign imem_we    = we_q;
   assign imem_addr  = waddr_q;
   assign imem_wdata = wdata_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: cycle model of the loader plus hand-computed word/address pins.
module tb_instr_encoder_loader;
   import instr_encoder_loader_pkg::*;

   localparam int unsigned INSTR_W = 20;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned CNT_W   = 12;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [ADDR_W-1:0]  base_addr = '0;
   logic [CNT_W-1:0]   count = '0;
   logic               abort = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [2:0]         cls = '0, fn = '0, rd = '0, rs = '0, rt = '0;
   logic [7:0]         imm = '0;
   logic [ADDR_W-1:0]  target = '0;
   logic               imem_we;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic               cpu_hold, done, err;

   always #5 clk = ~clk;

   instr_encoder_loader #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cls        (cls),
      .fn         (fn),
      .rd         (rd),
      .rs         (rs),
      .rt         (rt),
      .imm        (imm),
      .target     (target),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Word built by plain arithmetic from the encoding table.
   function automatic int unsigned encode(input int unsigned c, input int unsigned f,
                                          input int unsigned d, input int unsigned s,
                                          input int unsigned t, input int unsigned im,
                                          input int unsigned tg);
      int unsigned opc = 0;
      int unsigned ops = 0;
      case (c)
         0: begin opc = 32'(REGISTER_TYPE_OPCODE) * 16 + f; ops = d * 2048 + s * 256 + t * 32; end
         1: begin opc = 32'(IMMEDIATE_TYPE_OPCODE) * 16 + f; ops = d * 2048 + s * 256 + im; end
         2: begin opc = 32'(SHIFT_TYPE_OPCODE) * 8 + f; ops = d * 2048 + s * 256 + im; end
         3: begin opc = 32'(MEMORY_TYPE_OPCODE) * 8 + (f % 4) * 2; ops = d * 2048 + s * 256 + im; end
         4: begin opc = 32'(CONDITIONAL_JUMP_TYPE_OPCODE) * 8 + (f % 4) * 2; ops = im; end
         5: begin opc = 32'(NON_CONDITIONAL_JUMP_TYPE_OPCODE) * 4; ops = tg; end
         default: ;
      endcase
      return opc * 16384 + ops;
   endfunction

   function automatic bit is_illegal(input int unsigned c, input int unsigned f);
      return (c > 5) || (c == 3 && (f % 4) != 32'(STM_FN) && (f % 4) != 32'(LDM_FN));
   endfunction

   // Behavioural model: 0 = idle, 1 = loading, 2 = finishing pulse.
   int          m_st = 0;
   int unsigned m_addr = 0, m_left = 0;
   bit          m_err = 1'b0;
   bit          e_we = 1'b0;
   int unsigned e_addr = 0, e_word = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0; m_addr <= 0; m_left <= 0; m_err <= 1'b0;
         e_we <= 1'b0; e_addr <= 0; e_word <= 0;
      end else begin
         e_we <= 1'b0;
         case (m_st)
            0: if (start) begin
               m_addr <= 32'(base_addr);
               m_left <= 32'(count);
               m_err  <= 1'b0;
               m_st   <= (count == '0) ? 2 : 1;
            end
            1: if (abort) begin
               m_st <= 0;
            end else if (in_valid) begin
               if (is_illegal(32'(cls), 32'(fn))) begin
                  m_err <= 1'b1;
               end else begin
                  e_we   <= 1'b1;
                  e_addr <= m_addr;
                  e_word <= encode(32'(cls), 32'(fn), 32'(rd), 32'(rs), 32'(rt), 32'(imm), 32'(target));
                  m_addr <= (m_addr + 1) % 4096;
                  m_left <= m_left - 1;
                  if (m_left == 1) m_st <= 2;
               end
            end
            default: m_st <= 0;
         endcase
      end
   end

   logic [ADDR_W-1:0]  obs_addr[$];
   logic [INSTR_W-1:0] obs_word[$];
   logic               obs_done[$];
   int                 n_done = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("imem_we", 32'(imem_we), 32'(e_we));
         if (e_we) begin
            chk("imem_addr", 32'(imem_addr), e_addr);
            chk("imem_wdata", 32'(imem_wdata), e_word);
         end
         chk("in_ready", 32'(in_ready), 32'(m_st == 1));
         chk("cpu_hold", 32'(cpu_hold), 32'(m_st != 0));
         chk("done", 32'(done), 32'(m_st == 2));
         chk("err", 32'(err), 32'(m_err));
         if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_word.push_back(imem_wdata);
            obs_done.push_back(done);
         end
         if (done) n_done++;
      end
   end

   task automatic clear_obs();
      obs_addr.delete();
      obs_word.delete();
      obs_done.delete();
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
      @(negedge clk);
      start = 1'b1; base_addr = b; count = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [2:0] c, input logic [2:0] f, input logic [2:0] d,
                       input logic [2:0] s, input logic [2:0] t, input logic [7:0] im,
                       input logic [ADDR_W-1:0] tg);
      in_valid = 1'b1; cls = c; fn = f; rd = d; rs = s; rt = t; imm = im; target = tg;
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      in_valid = 1'b0;
      for (int unsigned i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
      chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int d0;

   initial begin
      #12;
      chk_all_zero("reset");
      @(posedge clk); #2 rst_n = 1'b1;

      // Basic R / I / JMP load.
      clear_obs();
      do_start(12'h010, 12'd3);
      send(3'd0, 3'b010, 3'd1, 3'd2, 3'd3, 8'h00, 12'h000);
      send(3'd1, 3'b001, 3'd4, 3'd0, 3'd0, 8'h7F, 12'h000);
      send(3'd5, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 12'h0AB);
      idle(3);
      chk("s1_nwrites", 32'(obs_addr.size()), 32'd3);
      if (obs_addr.size() == 3) begin
         chk("s1_addr0", 32'(obs_addr[0]), 32'h010);
         chk("s1_addr1", 32'(obs_addr[1]), 32'h011);
         chk("s1_addr2", 32'(obs_addr[2]), 32'h012);
         chk("s1_word_r", 32'(obs_word[0]), 32'h08A60);
         chk("s1_word_i", 32'(obs_word[1]), 32'h4607F);
         chk("s1_word_jmp", 32'(obs_word[2]), 32'hE00AB);
         chk("s1_done_last", 32'(obs_done[2]), 32'd1);
         chk("s1_done_first", 32'(obs_done[0]), 32'd0);
      end

      // Address wrap.
      clear_obs();
      do_start(12'hFFE, 12'd3);
      send(3'd2, 3'b101, 3'd7, 3'd6, 3'd0, 8'h03, 12'h000);
      send(3'd1, 3'b111, 3'd3, 3'd3, 3'd0, 8'hA5, 12'h000);
      send(3'd3, 3'b100, 3'd1, 3'd2, 3'd0, 8'h5A, 12'h000);
      idle(3);
      chk("s2_nwrites", 32'(obs_addr.size()), 32'd3);
      if (obs_addr.size() == 3) begin
         chk("s2_addr0", 32'(obs_addr[0]), 32'hFFE);
         chk("s2_addr1", 32'(obs_addr[1]), 32'hFFF);
         chk("s2_addr2", 32'(obs_addr[2]), 32'h000);
      end

      // Illegal MEM fn, then LDM and CJMP BNZ.
      clear_obs();
      do_start(12'h040, 12'd2);
      send(3'd3, 3'b010, 3'd1, 3'd1, 3'd0, 8'h11, 12'h000);
      send(3'd3, 3'b001, 3'd2, 3'd5, 3'd0, 8'h33, 12'h000);
      send(3'd4, {1'b0, BNZ_FN}, 3'd7, 3'd7, 3'd7, 8'hF0, 12'hFFF);
      idle(3);
      chk("s3_nwrites", 32'(obs_addr.size()), 32'd2);
      if (obs_addr.size() == 2) begin
         chk("s3_addr0", 32'(obs_addr[0]), 32'h040);
         chk("s3_word_ldm", 32'(obs_word[0]), 32'hA9533);
         chk("s3_word_cjmp", 32'(obs_word[1]), 32'hD00F0);
      end
      chk("s3_err_sticky", 32'(err), 32'd1);

      // Abort after two acceptances with in_valid held.
      clear_obs();
      d0 = n_done;
      do_start(12'h080, 12'd4);
      send(3'd0, 3'b001, 3'd1, 3'd1, 3'd1, 8'h00, 12'h000);
      send(3'd0, 3'b011, 3'd2, 3'd2, 3'd2, 8'h00, 12'h000);
      abort = 1'b1;
      send(3'd0, 3'b100, 3'd3, 3'd3, 3'd3, 8'h00, 12'h000);
      abort = 1'b0;
      idle(3);
      chk("s4_nwrites", 32'(obs_addr.size()), 32'd2);
      chk("s4_no_done", 32'(n_done - d0), 32'd0);
      chk("s4_hold", 32'(cpu_hold), 32'd0);
      chk("s4_err_cleared", 32'(err), 32'd0);

      // Zero count, then a start ignored during LOAD.
      clear_obs();
      d0 = n_done;
      do_start(12'h100, 12'd0);
      idle(3);
      chk("s5_zero_done", 32'(n_done - d0), 32'd1);
      chk("s5_zero_writes", 32'(obs_addr.size()), 32'd0);
      d0 = n_done;
      do_start(12'h200, 12'd2);
      start = 1'b1; base_addr = 12'h300; count = 12'd5;
      send(3'd1, 3'b000, 3'd1, 3'd0, 3'd0, 8'h01, 12'h000);
      start = 1'b0;
      send(3'd1, 3'b000, 3'd2, 3'd0, 3'd0, 8'h02, 12'h000);
      idle(3);
      chk("s5_nwrites", 32'(obs_addr.size()), 32'd2);
      if (obs_addr.size() == 2) begin
         chk("s5_addr0", 32'(obs_addr[0]), 32'h200);
         chk("s5_addr1", 32'(obs_addr[1]), 32'h201);
      end
      chk("s5_done", 32'(n_done - d0), 32'd1);

      // Asynchronous reset with a write on the bus.
      do_start(12'h050, 12'd3);
      send(3'd6, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 12'h000);
      in_valid = 1'b1; cls = 3'd0; fn = 3'b001; rd = 3'd5; rs = 3'd6; rt = 3'd7;
      @(posedge clk); #1;
      chk("s6_pending_we", 32'(imem_we), 32'd1);
      chk("s6_err_before", 32'(err), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("s6_async");
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
      clear_obs();
      do_start(12'h020, 12'd1);
      send(3'd0, 3'b000, 3'd1, 3'd1, 3'd1, 8'h00, 12'h000);
      idle(3);
      chk("s6_nwrites", 32'(obs_addr.size()), 32'd1);
      if (obs_addr.size() == 1) chk("s6_addr", 32'(obs_addr[0]), 32'h020);
      chk("s6_err_after", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
